// File: rtl/usb_rx_if.sv
// usb_rx_if: FT245 read port and chunk/row buffer write port of usb_rx_sequencer.
interface usb_rx_if;
    logic        rxf_n;
    logic [7:0]  data_bus;
    logic        rd_n;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_data_addr;
    logic        chunk_data_write_enable;
    logic [3:0]  row_data_row_addr;
    logic [1:0]  row_data_panel_addr;
    logic        frame_done;
    logic        frame_error;
    modport master (
        input  rxf_n, data_bus,
        output rd_n, chunk_data, chunk_data_addr, chunk_data_write_enable,
               row_data_row_addr, row_data_panel_addr, frame_done, frame_error
    );
    modport slave (
        output rxf_n, data_bus,
        input  rd_n, chunk_data, chunk_data_addr, chunk_data_write_enable,
               row_data_row_addr, row_data_panel_addr, frame_done, frame_error
    );
endinterface

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer: FT245 read strobe timing plus row-packet parser into 32-bit chunk writes.
// Define USB_RX_TIMEOUT_EN to abort packets that stall for TIMEOUT_CYCLES between bytes.
module usb_rx_sequencer #(
    parameter int unsigned RD_LOW_CYCLES  = 4,
    parameter int unsigned RD_HIGH_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  SYNC_BYTE      = 8'hE5
) (
    input  logic     clk,
    input  logic     reset_n,
    usb_rx_if.master bus
);
    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} byte_state_t;
    typedef enum logic [1:0] {HUNT_SYNC, GET_ADDR, GET_PAYLOAD} parse_state_t;
    byte_state_t  bstate, bstate_nx;
    parse_state_t pstate, pstate_nx;
    logic [3:0]   cnt;
    logic         cnt_last, cap, timeout, addr_ok;
    logic [1:0]   bcnt;
    logic [3:0]   widx;
    logic [23:0]  word;
    assign cnt_last = cnt == (bstate == STROBE ? 4'(RD_LOW_CYCLES - 1) : 4'(RD_HIGH_CYCLES - 1));
    assign cap      = bstate == STROBE && cnt_last;
    assign addr_ok  = bus.data_bus[1:0] == 2'b00;
    always_comb begin
        bstate_nx = bstate;
        case (bstate)
            IDLE:    if (!bus.rxf_n) bstate_nx = STROBE;
            STROBE:  if (cnt_last) bstate_nx = RECOVER;
            default: if (cnt_last) bstate_nx = IDLE;
        endcase
    end
    // rd_n is registered off the next state so reset forces it high without a clock
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bstate   <= IDLE;
            cnt      <= '0;
            bus.rd_n <= 1'b1;
        end else begin
            bstate   <= bstate_nx;
            cnt      <= bstate_nx != bstate ? 4'd0 : cnt + 4'd1;
            bus.rd_n <= bstate_nx != STROBE;
        end
    always_comb begin
        pstate_nx = pstate;
        if (timeout) pstate_nx = HUNT_SYNC;
        else if (cap)
            case (pstate)
                HUNT_SYNC: if (bus.data_bus == SYNC_BYTE) pstate_nx = GET_ADDR;
                GET_ADDR:  pstate_nx = addr_ok ? GET_PAYLOAD : HUNT_SYNC;
                default:   if (bcnt == 2'd3 && widx == 4'd15) pstate_nx = HUNT_SYNC;
            endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pstate                      <= HUNT_SYNC;
            bcnt                        <= '0;
            widx                        <= '0;
            word                        <= '0;
            bus.chunk_data              <= '0;
            bus.chunk_data_addr         <= '0;
            bus.chunk_data_write_enable <= 1'b0;
            bus.row_data_row_addr       <= '0;
            bus.row_data_panel_addr     <= '0;
            bus.frame_done              <= 1'b0;
            bus.frame_error             <= 1'b0;
        end else begin
            pstate                      <= pstate_nx;
            bus.chunk_data_write_enable <= 1'b0;
            bus.frame_done              <= 1'b0;
            bus.frame_error             <= timeout || (cap && pstate == GET_ADDR && !addr_ok);
            if (cap && pstate == GET_ADDR && addr_ok) begin
                bus.row_data_panel_addr <= bus.data_bus[7:6];
                bus.row_data_row_addr   <= bus.data_bus[5:2];
                bcnt                    <= '0;
                widx                    <= '0;
            end
            if (cap && pstate == GET_PAYLOAD) begin
                bcnt <= bcnt + 2'd1;
                word <= {word[15:0], bus.data_bus};
                if (bcnt == 2'd3) begin
                    bus.chunk_data              <= {word, bus.data_bus};
                    bus.chunk_data_addr         <= widx;
                    bus.chunk_data_write_enable <= 1'b1;
                    bus.frame_done              <= widx == 4'd15;
                    widx                        <= widx + 4'd1;
                end
            end
        end
`ifdef USB_RX_TIMEOUT_EN
    logic [15:0] tcnt;
    assign timeout = !cap && pstate != HUNT_SYNC && tcnt == 16'(TIMEOUT_CYCLES);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) tcnt <= '0;
        else tcnt <= (cap || pstate_nx == HUNT_SYNC) ? 16'd0 : tcnt + 16'd1;
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
endmodule
